// File: rtl/rxtx_pkg.sv
// rtl/rxtx_pkg.sv - shared LVDS bridge types and geometry helpers for the gate folder and unfolder
package rxtx_pkg;

  typedef enum logic [1:0] {HUNT, LOCKED, COLLECT, PUBLISH} rx_state_t;

  function automatic int word_width(input int channels, input int serialization);
    return channels * serialization;
  endfunction

  function automatic int payload_width(input int gate_width, input int flit_width);
    return gate_width * (flit_width + 2);
  endfunction

  function automatic int vl_offset(input int gate_width, input int flit_width);
    return gate_width * flit_width;
  endfunction

  function automatic int cr_offset(input int gate_width, input int flit_width);
    return gate_width * flit_width + gate_width;
  endfunction

  // Callers truncate to their word width; bits above w are left zero.
  function automatic logic [255:0] sync_word(input int w, input logic pattern);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 256; i++) begin
      if (i < w) r[i] = pattern;
    end
    return r;
  endfunction

endpackage

// File: rtl/rx_sync_detect.sv
// rtl/rx_sync_detect.sv - counts consecutive sync words while hunting and raises a sticky lock flag
module rx_sync_detect #(
  parameter int STABLE_CYCLES = 1000000,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hunt,
  input  logic             word_vl,
  input  logic             is_sync,
  output logic             lock,
  output logic [CNT_W-1:0] lock_cnt
);

  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] STABLE_M1  = CNT_W'(STABLE_CYCLES - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt <= '0;
      lock     <= 1'b0;
    end else if (hunt && word_vl) begin
      if (is_sync) begin
        if (lock_cnt != STABLE_MAX) lock_cnt <= lock_cnt + 1'b1;
        // The word being accepted now is the one that completes the run.
        if (lock_cnt >= STABLE_M1) lock <= 1'b1;
      end else begin
        lock_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/rx_gate_unfolder.sv
// rtl/rx_gate_unfolder.sv - sync hunt, frame reassembly and pull handshake; RX_GATE_PARITY_EN enables frame parity
module rx_gate_unfolder
  import rxtx_pkg::*;
#(
  parameter int   FLIT_WIDTH         = 8,
  parameter int   GATE_WIDTH         = 8,
  parameter int   GATE_FOLDS         = 3,
  parameter logic SYNC_PATTERN       = 1'b1,
  parameter int   STABLE_CYCLES      = 1000000,
  parameter int   LVDS_CHANNELS      = 7,
  parameter int   LVDS_SERIALIZATION = 4,
  localparam int  W                  = word_width(LVDS_CHANNELS, LVDS_SERIALIZATION)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [W-1:0]          i_word,
  input  logic                  i_word_vl,
  input  logic                  i_rx_pull,
  output logic                  o_rx_available,
  output logic                  o_sync_complete,
  output logic [FLIT_WIDTH-1:0] o_dt [GATE_WIDTH-1:0],
  output logic [GATE_WIDTH-1:0] o_vl,
  output logic [GATE_WIDTH-1:0] o_cr,
  output logic                  o_err_overrun,
  output logic                  o_err_parity
);

  localparam int P      = payload_width(GATE_WIDTH, FLIT_WIDTH);
  localparam int SH_W   = GATE_FOLDS * W;
  localparam int VL_OFF = vl_offset(GATE_WIDTH, FLIT_WIDTH);
  localparam int CR_OFF = cr_offset(GATE_WIDTH, FLIT_WIDTH);
  localparam int FOLD_W = (GATE_FOLDS > 1) ? $clog2(GATE_FOLDS) : 1;
  localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);

  localparam logic [W-1:0]      SYNC_WORD = W'(sync_word(W, SYNC_PATTERN));
  localparam logic [W-1:0]      HEAD_WORD = ~SYNC_WORD;
  localparam logic [FOLD_W-1:0] LAST_FOLD = FOLD_W'(GATE_FOLDS - 1);
  localparam logic [CNT_W-1:0]  STABLE_M1 = CNT_W'(STABLE_CYCLES - 1);

`ifdef RX_GATE_PARITY_EN
  generate
    if (SH_W < P + 1) begin : g_fold_check
      $error("GATE_FOLDS*W too small for payload plus parity bit");
    end
  endgenerate
`else
  generate
    if (SH_W < P) begin : g_fold_check
      $error("GATE_FOLDS*W too small for payload");
    end
  endgenerate
`endif

  rx_state_t         state, state_n;
  logic [FOLD_W-1:0] fold_idx, fold_n;
  logic [SH_W-1:0]   shadow, shadow_n;
  logic              publish, parity_ok, accept;
  logic              lock;
  logic [CNT_W-1:0]  lock_cnt;
  logic              is_sync, is_head, lock_hit;

  assign is_sync  = (i_word == SYNC_WORD);
  assign is_head  = (i_word == HEAD_WORD);
  assign lock_hit = (state == HUNT) && i_word_vl && is_sync && (lock_cnt >= STABLE_M1);

  rx_sync_detect #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_sync_detect (
    .clk      (i_clk),
    .rst_n    (i_rst),
    .hunt     (state == HUNT),
    .word_vl  (i_word_vl),
    .is_sync  (is_sync),
    .lock     (lock),
    .lock_cnt (lock_cnt)
  );

  // PUBLISH is the cycle the new sample is first visible; incoming words are
  // handled as in LOCKED so a back-to-back header is not lost.
  always_comb begin
    state_n  = state;
    fold_n   = fold_idx;
    shadow_n = shadow;
    publish  = 1'b0;
    if (i_word_vl) begin
      case (state)
        HUNT: if (lock_hit) state_n = LOCKED;
        LOCKED, PUBLISH: begin
          state_n = LOCKED;
          if (is_head) begin
            state_n = COLLECT;
            fold_n  = '0;
          end
        end
        COLLECT: begin
          if (is_head) begin
            fold_n = '0;
          end else begin
            shadow_n[int'(fold_idx)*W +: W] = i_word;
            if (fold_idx == LAST_FOLD) begin
              publish = 1'b1;
              state_n = PUBLISH;
              fold_n  = '0;
            end else begin
              fold_n = fold_idx + 1'b1;
            end
          end
        end
        default: state_n = HUNT;
      endcase
    end else if (state == PUBLISH) begin
      state_n = LOCKED;
    end
  end

`ifdef RX_GATE_PARITY_EN
  assign parity_ok = ~^shadow_n[P:0];
`else
  assign parity_ok = 1'b1;
`endif
  assign accept = publish && parity_ok;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state    <= HUNT;
      fold_idx <= '0;
      shadow   <= '0;
    end else begin
      state    <= state_n;
      fold_idx <= fold_n;
      shadow   <= shadow_n;
    end
  end

  // Outputs load from shadow_n so the sample is visible the cycle after its last word.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_rx_available <= 1'b0;
      o_err_overrun  <= 1'b0;
      o_vl           <= '0;
      o_cr           <= '0;
      for (int i = 0; i < GATE_WIDTH; i++) o_dt[i] <= '0;
    end else if (accept) begin
      o_rx_available <= 1'b1;
      if (o_rx_available && !i_rx_pull) o_err_overrun <= 1'b1;
      o_vl <= shadow_n[VL_OFF +: GATE_WIDTH];
      o_cr <= shadow_n[CR_OFF +: GATE_WIDTH];
      for (int i = 0; i < GATE_WIDTH; i++) o_dt[i] <= shadow_n[i*FLIT_WIDTH +: FLIT_WIDTH];
    end else if (i_rx_pull && o_rx_available) begin
      o_rx_available <= 1'b0;
    end
  end

`ifdef RX_GATE_PARITY_EN
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_err_parity <= 1'b0;
    end else if (publish && !parity_ok) begin
      o_err_parity <= 1'b1;
    end
  end
`else
  assign o_err_parity = 1'b0;
`endif

  assign o_sync_complete = lock;

endmodule
